// File: rtl/ofm_pack_writer.sv
// OFM pack writer: captures 16-byte conv outputs into a 2-entry FIFO and
// drains each pixel as four 32-bit BRAM words (big-endian byte packing).
module ofm_pack_writer #(
    parameter int unsigned NUM_PIXELS = 3136,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       valid,
    input  logic [127:0]      ofm_in,
    output logic              we_OFM,
    output logic [ADDR_W-1:0] addr_OFM,
    output logic [31:0]       data_out_OFM,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              partial_err
);

    localparam int unsigned     CntW   = $clog2(NUM_PIXELS + 1);
    localparam logic [CntW-1:0] NumPix = CntW'(NUM_PIXELS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [127:0]    fifo_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [CntW-1:0] cap_cnt_q;
    logic [CntW-1:0] pix_cnt_q;
    logic [1:0]      word_q;

    logic [127:0]      head;
    logic [31:0]       word_data;
    logic [ADDR_W-1:0] word_addr;
    logic              emit;
    logic              pop;
    logic              pixel_valid;
    logic              partial_valid;
    logic              push;
    logic              drop;

    // Head-word selection, address generation and FIFO push/pop decisions
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        word_data = '0;
        for (int j = 0; j < 4; j++) begin
            word_data[31-8*j -: 8] = head[8*(4*int'(word_q) + j) +: 8];
        end
        word_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'({pix_cnt_q, 2'b00}) + ADDR_W'(word_q);
        emit          = (count_q != 2'd0);
        pop           = emit && (word_q == 2'd3);
        pixel_valid   = (valid == 16'hFFFF);
        partial_valid = (valid != 16'h0000) && !pixel_valid;
        // A full FIFO still accepts a pixel when the head is leaving this cycle
        push          = pixel_valid && (cap_cnt_q != NumPix) && ((count_q != 2'd2) || pop);
        drop          = pixel_valid && !push;
    end

    // Frame FSM, FIFO bookkeeping and registered BRAM/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            cap_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            word_q       <= 2'd0;
            we_OFM       <= 1'b0;
            addr_OFM     <= '0;
            data_out_OFM <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            partial_err  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    we_OFM <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        state_q     <= StRun;
                        busy        <= 1'b1;
                        wr_ptr_q    <= 1'b0;
                        rd_ptr_q    <= 1'b0;
                        count_q     <= 2'd0;
                        cap_cnt_q   <= '0;
                        pix_cnt_q   <= '0;
                        word_q      <= 2'd0;
                        overflow    <= 1'b0;
                        partial_err <= 1'b0;
                    end
                end
                StRun: begin
                    // Last pixel's word 3 went out last cycle; finish the frame now
                    if (pix_cnt_q == NumPix) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        we_OFM  <= 1'b0;
                    end else begin
                        we_OFM <= emit;
                        if (emit) begin
                            addr_OFM     <= word_addr;
                            data_out_OFM <= word_data;
                            word_q       <= word_q + 2'd1;
                        end
                        if (pop) begin
                            rd_ptr_q  <= ~rd_ptr_q;
                            pix_cnt_q <= pix_cnt_q + CntW'(1);
                        end
                    end
                    if (push) begin
                        fifo_q[wr_ptr_q] <= ofm_in;
                        wr_ptr_q         <= ~wr_ptr_q;
                        cap_cnt_q        <= cap_cnt_q + CntW'(1);
                    end
                    if (push && !pop) begin
                        count_q <= count_q + 2'd1;
                    end else if (pop && !push) begin
                        count_q <= count_q - 2'd1;
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (partial_valid) begin
                        partial_err <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    we_OFM  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Self-checking bench for ofm_pack_writer: directed frame scenarios plus
// randomized frames, all checked against a queue-based pixel/word model.
module tb_ofm_pack_writer;

    localparam int NP = 4;
    localparam int AW = 20;
    localparam int BA = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   valid;
    logic [127:0]  ofm_in;
    logic          we_OFM;
    logic [AW-1:0] addr_OFM;
    logic [31:0]   data_out_OFM;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          partial_err;

    ofm_pack_writer #(
        .NUM_PIXELS(NP),
        .ADDR_W    (AW),
        .BASE_ADDR (BA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valid       (valid),
        .ofm_in      (ofm_in),
        .we_OFM      (we_OFM),
        .addr_OFM    (addr_OFM),
        .data_out_OFM(data_out_OFM),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .partial_err (partial_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pixels waiting to be written, plus expected outputs
    int            m_phase;  // 0 idle, 1 run, 2 done
    logic [127:0]  m_q[$];
    int            m_word;
    int            m_cap;
    int            m_pix;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    logic          e_busy;
    logic          e_done;
    logic          e_ovf;
    logic          e_perr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("we_OFM", 32'(we_OFM), 32'(e_we));
        chk("addr_OFM", 32'(addr_OFM), 32'(e_addr));
        chk("data_out_OFM", data_out_OFM, e_data);
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("partial_err", 32'(partial_err), 32'(e_perr));
    endtask

    // Word w of a pixel: bytes 4w..4w+3, lowest-numbered byte most significant
    function automatic logic [31:0] word_of(input logic [127:0] p, input int w);
        logic [31:0] d = 0;
        for (int j = 0; j < 4; j++) d = d * 256 + 32'(p[8*(4*w+j) +: 8]);
        return d;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_q.delete();
        m_word = 0;
        m_cap  = 0;
        m_pix  = 0;
        e_we   = 0;
        e_addr = 0;
        e_data = 0;
        e_busy = 0;
        e_done = 0;
        e_ovf  = 0;
        e_perr = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_clock();
        bit pop_now;
        pop_now = 0;
        case (m_phase)
            0: begin
                e_we   = 0;
                e_done = 0;
                if (start) begin
                    m_phase = 1;
                    e_busy  = 1;
                    m_q.delete();
                    m_word = 0;
                    m_cap  = 0;
                    m_pix  = 0;
                    e_ovf  = 0;
                    e_perr = 0;
                end
            end
            1: begin
                if (m_pix == NP) begin
                    m_phase = 2;
                    e_done  = 1;
                    e_busy  = 0;
                    e_we    = 0;
                end else if (m_q.size() > 0) begin
                    e_we    = 1;
                    e_addr  = AW'(BA + 4 * m_pix + m_word);
                    e_data  = word_of(m_q[0], m_word);
                    pop_now = (m_word == 3);
                    m_word  = (m_word + 1) % 4;
                end else begin
                    e_we = 0;
                end
                if (valid == 16'hFFFF) begin
                    if (m_cap == NP) e_ovf = 1;
                    else if (m_q.size() < 2 || pop_now) begin
                        m_q.push_back(ofm_in);
                        m_cap++;
                    end else e_ovf = 1;
                end else if (valid != 16'h0000) begin
                    e_perr = 1;
                end
                if (pop_now) begin
                    void'(m_q.pop_front());
                    m_pix++;
                end
            end
            default: begin
                m_phase = 0;
                e_done  = 0;
                e_we    = 0;
            end
        endcase
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        valid = 16'h0000;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pixel_step(input logic [127:0] p);
        valid  = 16'hFFFF;
        ofm_in = p;
        step();
        valid = 16'h0000;
    endtask

    function automatic logic [127:0] rand_pixel();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Run with idle inputs until the frame returns to IDLE; bounded
    task automatic finish_frame(input string tag);
        valid = 16'h0000;
        for (int i = 0; i < 200 && m_phase != 0; i++) step();
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] seq_pix;
        for (int k = 0; k < 16; k++) seq_pix[8*k +: 8] = 8'(k);

        reset  = 1'b1;
        start  = 1'b0;
        valid  = 16'h0000;
        ofm_in = '0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();

        // valid in IDLE: no write, no flags
        valid  = 16'hFFFF;
        ofm_in = rand_pixel();
        for (int i = 0; i < 5; i++) step();
        valid = 16'h0000;

        // Known bytes, then three more pixels spaced 36 cycles apart
        start_frame();
        pixel_step(seq_pix);
        step();
        chk("seq_w0_data", data_out_OFM, 32'h00010203);
        chk("seq_w0_addr", 32'(addr_OFM), 32'd0);
        step();
        chk("seq_w1_data", data_out_OFM, 32'h04050607);
        step();
        chk("seq_w2_data", data_out_OFM, 32'h08090A0B);
        step();
        chk("seq_w3_data", data_out_OFM, 32'h0C0D0E0F);
        chk("seq_w3_addr", 32'(addr_OFM), 32'd3);
        idle_steps(32);
        for (int p = 0; p < NP - 1; p++) begin
            pixel_step(rand_pixel());
            idle_steps(35);
        end
        finish_frame("spaced_frame_end");
        chk("spaced_ovf", 32'(overflow), 32'd0);

        // Three back-to-back pixels: third is dropped
        start_frame();
        for (int i = 0; i < 3; i++) begin
            valid  = 16'hFFFF;
            ofm_in = rand_pixel();
            step();
        end
        idle_steps(12);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_last_addr", 32'(addr_OFM), 32'd7);
        pixel_step(rand_pixel());
        idle_steps(8);
        pixel_step(rand_pixel());
        finish_frame("burst_frame_end");

        // Partial valid is ignored but flagged
        start_frame();
        valid  = 16'h00FF;
        ofm_in = rand_pixel();
        step();
        valid = 16'h0000;
        chk("partial_flag", 32'(partial_err), 32'd1);
        idle_steps(3);
        chk("partial_no_write", 32'(we_OFM), 32'd0);
        pixel_step(rand_pixel());
        step();
        chk("after_partial_addr", 32'(addr_OFM), 32'd0);
        chk("after_partial_we", 32'(we_OFM), 32'd1);
        for (int p = 0; p < NP - 1; p++) begin
            idle_steps(6);
            pixel_step(rand_pixel());
        end
        finish_frame("partial_frame_end");
        chk("partial_sticky", 32'(partial_err), 32'd1);

        // Reset while word 2 is on the bus
        start_frame();
        pixel_step(rand_pixel());
        idle_steps(3);
        chk("pre_reset_addr", 32'(addr_OFM), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid  = 16'hFFFF;
        ofm_in = rand_pixel();
        for (int i = 0; i < 8; i++) step();
        valid = 16'h0000;
        chk("post_reset_no_write", 32'(we_OFM), 32'd0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            start_frame();
            for (int c = 0; c < 400 && m_phase != 0; c++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) valid = 16'h0000;
                else if (r < 9) valid = 16'hFFFF;
                else valid = 16'($urandom_range(1, 16'hFFFE));
                ofm_in = rand_pixel();
                start  = ($urandom_range(0, 9) == 0);
                step();
            end
            start = 1'b0;
            valid = 16'h0000;
            chk("rand_frame_end", 32'(busy), 32'd0);
            idle_steps($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofm_pack_writer.md
OFM_PACK_WRITER -- requirements
Module: ofm_pack_writer

Interface
REQ-001 Parameter NUM_PIXELS, default 3136, gives the OFM pixels per frame (56x56).
REQ-002 Parameter ADDR_W, default 20, gives the OFM BRAM word-address width.
REQ-003 Parameter BASE_ADDR, default 0, gives the first OFM BRAM word address.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: single-cycle frame start, sampled only in IDLE.
REQ-007 Port valid, input, 16 bits: per-PE OFM valid flags from the conv stage.
REQ-008 Port ofm_in, input, 128 bits: byte k = ofm_in[8k+7:8k] = PE k output channel.
REQ-009 Port we_OFM, output, 1 bit: OFM BRAM write enable.
REQ-010 Port addr_OFM, output, ADDR_W bits: OFM BRAM word address.
REQ-011 Port data_out_OFM, output, 32 bits: OFM BRAM write data.
REQ-012 Port busy, output, 1 bit: high in RUN.
REQ-013 Port done, output, 1 bit: one-cycle pulse at frame end.
REQ-014 Port overflow, output, 1 bit: sticky flag for a dropped pixel.
REQ-015 Port partial_err, output, 1 bit: sticky flag for a partial valid.

Function
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last word of pixel NUM_PIXELS-1 is written; DONE->IDLE after one cycle.
REQ-017 On entering RUN: clear capture count, pixel count, word index, FIFO, overflow and partial_err.
REQ-018 In RUN, valid==16'hFFFF with FIFO not full and capture count < NUM_PIXELS pushes all 16 bytes into a 2-entry FIFO.
REQ-019 A push with FIFO full and no pop in the same cycle drops the pixel and sets overflow.
REQ-020 A push coinciding with the pop of the head's word 3 is accepted even when the FIFO is full.
REQ-021 valid==16'hFFFF with capture count == NUM_PIXELS is ignored and sets overflow.
REQ-022 valid neither 0 nor 16'hFFFF is ignored and sets partial_err.
REQ-023 valid is ignored in IDLE and DONE; start is ignored in RUN and DONE.
REQ-024 While the FIFO is non-empty, emit one word per cycle, w = 0..3, from the head entry.
REQ-025 Word packing: data_out_OFM = {byte 4w, byte 4w+1, byte 4w+2, byte 4w+3}, with byte 4w in bits [31:24].
REQ-026 addr_OFM = BASE_ADDR + 4*pixel_cnt + w, truncated to ADDR_W (wrap-around, no flag).
REQ-027 Outputs are registered: a push at edge N (FIFO previously empty) gives we_OFM=1 for word 0 during the cycle after edge N+1, then words 1-3 on consecutive cycles.
REQ-028 After word 3: pop the head, increment pixel_cnt, reset w to 0; a following entry starts its word 0 on the next cycle with no bubble.
REQ-029 done asserts for one cycle in DONE; busy=0 in DONE; overflow and partial_err keep their values until the next start or reset.
REQ-030 When no write occurs, we_OFM=0 and addr_OFM and data_out_OFM hold their last values.

Reset
REQ-031 reset asserted at any time, including mid-frame, forces immediately: state=IDLE, FIFO empty, all counters 0, and every output 0 (we_OFM, addr_OFM, data_out_OFM, busy, done, overflow, partial_err).
REQ-032 After reset deasserts, no write occurs until a new start.

Verification
REQ-033 NUM_PIXELS=1, start, then one valid=FFFF with ofm_in bytes 0x00..0x0F -> 4 consecutive writes: addr 0..3, data 00010203, 04050607, 08090A0B, 0C0D0E0F; done one cycle later.
REQ-034 NUM_PIXELS=4, valid=FFFF pulses 36 cycles apart -> 16 writes to addr 0..15, overflow=0, one done pulse, then busy=0.
REQ-035 valid=FFFF on 3 consecutive cycles -> 8 writes to addr 0..7 (pixels 1-2 only), overflow=1.
REQ-036 valid=16'h00FF in RUN -> no write, partial_err=1; a later valid=FFFF is still written to addr 0..3.
REQ-037 reset pulsed during word 2 -> we_OFM=0 and all outputs 0 at once; valid=FFFF after release with no start -> no write.
REQ-038 valid=FFFF while IDLE -> no write, no flag set.
